// File: rtl/demux1_2_reg.sv
// Registered 1-to-2 demultiplexer: one valid/ready input steered to slot A, slot B, both, or dropped.
// Optional saturating drop counter enabled by defining DEMUX_DROP_CNT_EN.
module demux1_2_reg #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic [1:0]       sel_i,
   output logic             a_valid_o,
   input  logic             a_ready_i,
   output logic [WIDTH-1:0] a_data_o,
   output logic             b_valid_o,
   input  logic             b_ready_i,
   output logic [WIDTH-1:0] b_data_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] drop_cnt_o
);

   localparam logic [1:0] SEL_A     = 2'b00;
   localparam logic [1:0] SEL_B     = 2'b01;
   localparam logic [1:0] SEL_BCAST = 2'b10;

   logic free_a;
   logic free_b;
   logic accept;
   logic load_a;
   logic load_b;

   // A slot is free if empty or being drained on this edge.
   always_comb begin
      free_a = !a_valid_o | a_ready_i;
      free_b = !b_valid_o | b_ready_i;
      case (sel_i)
         SEL_A:     in_ready_o = free_a;
         SEL_B:     in_ready_o = free_b;
         SEL_BCAST: in_ready_o = free_a & free_b;
         default:   in_ready_o = 1'b1;
      endcase
   end

   // Broadcast only accepts when both slots are free, so both loads fire together or not at all.
   assign accept = in_valid_i & in_ready_o;
   assign load_a = accept & ((sel_i == SEL_A) | (sel_i == SEL_BCAST));
   assign load_b = accept & ((sel_i == SEL_B) | (sel_i == SEL_BCAST));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_valid_o <= 1'b0;
         a_data_o  <= '0;
      end else if (load_a) begin
         a_valid_o <= 1'b1;
         a_data_o  <= in_data_i;
      end else if (a_ready_i) begin
         a_valid_o <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         b_valid_o <= 1'b0;
         b_data_o  <= '0;
      end else if (load_b) begin
         b_valid_o <= 1'b1;
         b_data_o  <= in_data_i;
      end else if (b_ready_i) begin
         b_valid_o <= 1'b0;
      end
   end

   assign busy_o = a_valid_o | b_valid_o;

`ifdef DEMUX_DROP_CNT_EN
   logic             drop;
   logic [CNT_W-1:0] drop_cnt_q;

   assign drop = accept & (sel_i == 2'b11);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
         drop_cnt_q <= drop_cnt_q + 1'b1;
      end
   end

   assign drop_cnt_o = drop_cnt_q;
`else
   assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_demux1_2_reg.sv
// Directed vector bench for demux1_2_reg; drop-count expectations follow DEMUX_DROP_CNT_EN.
module tb_demux1_2_reg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 2;

   logic             clk_i;
   logic             rst_ni;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [WIDTH-1:0] in_data_i;
   logic [1:0]       sel_i;
   logic             a_valid_o;
   logic             a_ready_i;
   logic [WIDTH-1:0] a_data_o;
   logic             b_valid_o;
   logic             b_ready_i;
   logic [WIDTH-1:0] b_data_o;
   logic             busy_o;
   logic [CNT_W-1:0] drop_cnt_o;

   int total = 0;
   int bad   = 0;

   demux1_2_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_data_i  (in_data_i),
      .sel_i      (sel_i),
      .a_valid_o  (a_valid_o),
      .a_ready_i  (a_ready_i),
      .a_data_o   (a_data_o),
      .b_valid_o  (b_valid_o),
      .b_ready_i  (b_ready_i),
      .b_data_o   (b_data_o),
      .busy_o     (busy_o),
      .drop_cnt_o (drop_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [1:0]  sel;
      logic        valid;
      logic [31:0] data;
      logic        a_rdy;
      logic        b_rdy;
      logic        x_in_rdy;
      logic        x_a_v;
      logic [31:0] x_a_d;
      logic        x_b_v;
      logic [31:0] x_b_d;
      logic [1:0]  x_drop;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] drop_exp(input logic [1:0] on_val);
`ifdef DEMUX_DROP_CNT_EN
      return on_val;
`else
      return 2'd0;
`endif
   endfunction

   initial begin
      //         sel    v     data   ar    br    rdy   a_v   a_d    b_v   b_d    drop
      vecs[0]  = '{2'b00, 1'b1, 32'd5,  1'b1, 1'b1, 1'b1, 1'b1, 32'd5,  1'b0, 32'd0,  2'd0};
      vecs[1]  = '{2'b00, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 1'b0, 32'd5,  1'b0, 32'd0,  2'd0};
      vecs[2]  = '{2'b01, 1'b1, 32'd9,  1'b1, 1'b1, 1'b1, 1'b0, 32'd5,  1'b1, 32'd9,  2'd0};
      vecs[3]  = '{2'b01, 1'b0, 32'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'd5,  1'b0, 32'd9,  2'd0};
      vecs[4]  = '{2'b00, 1'b1, 32'd7,  1'b0, 1'b1, 1'b1, 1'b1, 32'd7,  1'b0, 32'd9,  2'd0};
      vecs[5]  = '{2'b10, 1'b1, 32'd6,  1'b0, 1'b1, 1'b0, 1'b1, 32'd7,  1'b0, 32'd9,  2'd0};
      vecs[6]  = '{2'b10, 1'b1, 32'd6,  1'b1, 1'b1, 1'b1, 1'b1, 32'd6,  1'b1, 32'd6,  2'd0};
      vecs[7]  = '{2'b00, 1'b1, 32'd8,  1'b1, 1'b1, 1'b1, 1'b1, 32'd8,  1'b0, 32'd6,  2'd0};
      vecs[8]  = '{2'b00, 1'b1, 32'd4,  1'b1, 1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd6,  2'd0};
      vecs[9]  = '{2'b00, 1'b1, 32'd2,  1'b1, 1'b1, 1'b1, 1'b1, 32'd2,  1'b0, 32'd6,  2'd0};
      vecs[10] = '{2'b11, 1'b1, 32'd3,  1'b0, 1'b0, 1'b1, 1'b1, 32'd2,  1'b0, 32'd6,  2'd1};
      vecs[11] = '{2'b11, 1'b1, 32'd3,  1'b0, 1'b0, 1'b1, 1'b1, 32'd2,  1'b0, 32'd6,  2'd2};
      vecs[12] = '{2'b11, 1'b1, 32'd3,  1'b0, 1'b0, 1'b1, 1'b1, 32'd2,  1'b0, 32'd6,  2'd3};
      vecs[13] = '{2'b11, 1'b1, 32'd3,  1'b0, 1'b0, 1'b1, 1'b1, 32'd2,  1'b0, 32'd6,  2'd3};
      vecs[14] = '{2'b11, 1'b1, 32'd3,  1'b0, 1'b0, 1'b1, 1'b1, 32'd2,  1'b0, 32'd6,  2'd3};
      vecs[15] = '{2'b01, 1'b0, 32'd0,  1'b0, 1'b1, 1'b1, 1'b1, 32'd2,  1'b0, 32'd6,  2'd3};
      vecs[16] = '{2'b01, 1'b1, 32'd11, 1'b0, 1'b0, 1'b1, 1'b1, 32'd2,  1'b1, 32'd11, 2'd3};
      vecs[17] = '{2'b01, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2,  1'b1, 32'd11, 2'd3};
      vecs[18] = '{2'b10, 1'b1, 32'd13, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2,  1'b1, 32'd11, 2'd3};

      rst_ni     = 1'b0;
      in_valid_i = 1'b0;
      in_data_i  = '0;
      sel_i      = 2'b00;
      a_ready_i  = 1'b0;
      b_ready_i  = 1'b0;
      #12;
      check("rst_a_valid", {31'd0, a_valid_o}, 32'd0);
      check("rst_b_valid", {31'd0, b_valid_o}, 32'd0);
      check("rst_a_data", a_data_o, 32'd0);
      check("rst_b_data", b_data_o, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_drop", {30'd0, drop_cnt_o}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(posedge clk_i); #1;
         sel_i      = vecs[i].sel;
         in_valid_i = vecs[i].valid;
         in_data_i  = vecs[i].data;
         a_ready_i  = vecs[i].a_rdy;
         b_ready_i  = vecs[i].b_rdy;
         #1;
         check($sformatf("v%0d_in_ready", i), {31'd0, in_ready_o}, {31'd0, vecs[i].x_in_rdy});
         @(posedge clk_i); #1;
         check($sformatf("v%0d_a_valid", i), {31'd0, a_valid_o}, {31'd0, vecs[i].x_a_v});
         check($sformatf("v%0d_a_data", i), a_data_o, vecs[i].x_a_d);
         check($sformatf("v%0d_b_valid", i), {31'd0, b_valid_o}, {31'd0, vecs[i].x_b_v});
         check($sformatf("v%0d_b_data", i), b_data_o, vecs[i].x_b_d);
         check($sformatf("v%0d_busy", i), {31'd0, busy_o},
               {31'd0, vecs[i].x_a_v | vecs[i].x_b_v});
         check($sformatf("v%0d_drop", i), {30'd0, drop_cnt_o}, {30'd0, drop_exp(vecs[i].x_drop)});
         in_valid_i = 1'b0;
         a_ready_i  = 1'b0;
         b_ready_i  = 1'b0;
      end

      // Both slots full here (A=2, B=11); reset mid-cycle must clear them before the next edge.
      @(posedge clk_i); #1;
      check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      check("midrst_a_valid", {31'd0, a_valid_o}, 32'd0);
      check("midrst_b_valid", {31'd0, b_valid_o}, 32'd0);
      check("midrst_busy", {31'd0, busy_o}, 32'd0);
      check("midrst_a_data", a_data_o, 32'd0);
      check("midrst_drop", {30'd0, drop_cnt_o}, 32'd0);
      sel_i = 2'b10;
      #1;
      check("midrst_in_ready", {31'd0, in_ready_o}, 32'd1);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      // After release, a broadcast loads both slots with one word.
      sel_i      = 2'b10;
      in_valid_i = 1'b1;
      in_data_i  = 32'hA5A5_0001;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      check("post_bcast_a", a_data_o, 32'hA5A5_0001);
      check("post_bcast_b", b_data_o, 32'hA5A5_0001);
      check("post_bcast_bv", {31'd0, b_valid_o}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/demux1_2_reg.md
Name: demux1_2_reg

Overview:
- Registered 1-to-2 demultiplexer: the inverse of the core's 2:1 operand mux.
- Steers one valid/ready input stream to output A, output B, both (broadcast) or nowhere (drop), under the 2-bit sel_i.
- Each output has a one-entry holding register with its own handshake, so one slow consumer never corrupts the other.
- Used wherever one producer (e.g. a writeback result) must feed one of two datapath consumers.

Parameters:
WIDTH, 32, data width of input and both outputs
CNT_W, 8, width of saturating drop counter (used only with the optional feature)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
in_valid_i  input  1  input word valid
in_ready_o  output  1  input word accepted this cycle when in_valid_i && in_ready_o
in_data_i  input  WIDTH  input word
sel_i  input  2  00=A, 01=B, 10=broadcast A and B, 11=drop
a_valid_o  output  1  slot A holds a word
a_ready_i  input  1  consumer A takes word when a_valid_o && a_ready_i
a_data_o  output  WIDTH  slot A word
b_valid_o  output  1  slot B holds a word
b_ready_i  input  1  consumer B handshake
b_data_o  output  WIDTH  slot B word
busy_o  output  1  a_valid_o | b_valid_o
drop_cnt_o  output  CNT_W  drops counted (only with DEMUX_DROP_CNT_EN)

Behaviour:
- Reset (async on rst_ni low, released synchronously by design):
  - a_valid_o=0, b_valid_o=0, a_data_o=0, b_data_o=0, drop_cnt_o=0.
  - busy_o=0.
  - in_ready_o follows its combinational equation (slots empty).
- Slot free term: freeA = !a_valid_o | a_ready_i; freeB = !b_valid_o | b_ready_i.
- in_ready_o is combinational from sel_i and the free terms:
  - 00: freeA
  - 01: freeB
  - 10: freeA & freeB
  - 11: 1
- No combinational path from in_data_i to any output.
- Accept to A (sel 00 or 10):
  - a_data_o <= in_data_i and a_valid_o <= 1 at the accepting edge.
  - Word is visible one cycle after acceptance (latency 1).
  - Same for B with sel 01 or 10.
- Broadcast is atomic: both slots load on the same edge, or neither does. Never a partial write.
- Drain: a_valid_o <= 0 on a_ready_i && a_valid_o unless a new word loads into A on the same edge. Simultaneous drain and load keeps valid=1 and carries the new data (full throughput, one word/cycle per output).
- Drop (sel 11): word accepted immediately and discarded; no slot changes.
- Slot valid/data are held stable while valid && !ready. Data changes only on load.
- Producer rule: sel_i and in_data_i stay stable while in_valid_i && !in_ready_o.
- Per-output order equals input order. There is no ordering relation between A and B.
- ready_i asserted with valid_o=0 has no effect.
- Reset mid-operation: held words are lost, both valids clear immediately, and no partial broadcast survives.

Optional Feature:
Macro DEMUX_DROP_CNT_EN.
- Defined:
  - drop_cnt_o increments by 1 on each accepted sel 11 word.
  - Saturates at 2^CNT_W-1, never wraps.
  - Cleared only by reset.
- Undefined:
  - Counter logic is absent.
  - drop_cnt_o is tied to 0.
  - Port list is unchanged.

Test Plan:
- Route to A: after reset, sel=00, data=5, valid 1 cycle, a_ready_i=1 -> next cycle a_valid_o=1, a_data_o=5; b_valid_o stays 0; following cycle a_valid_o=0.
- Route to B: sel=01, data=9 -> next cycle b_data_o=9, b_valid_o=1; a_data_o unchanged.
- Broadcast with backpressure:
  - a_ready_i=0 with A full (data 7), b_ready_i=1, sel=10, data=6 -> in_ready_o=0, B unchanged.
  - Raise a_ready_i -> same edge: A drains 7 and loads 6, B loads 6.
- Streaming: sel=00, data 8,4,2 on consecutive cycles with a_ready_i=1 -> a_data_o shows 8,4,2 on consecutive cycles, in_ready_o stays 1.
- Drop counter (macro on, CNT_W=2):
  - Five sel=11 words -> in_ready_o=1 every cycle.
  - drop_cnt_o reads 1,2,3,3,3.
  - No slot loads.
- Macro off: drop_cnt_o=0 throughout.
- Reset mid-operation: A and B both full, rst_ni low mid-cycle -> a_valid_o=b_valid_o=0 and busy_o=0 immediately, before the next clock edge.
